mem_port_arbiter: RTL

//  Shares the single-ported memory management unit between two requesters:

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data MMU port arbiter: FSM encoding,
// requester ids and the bus widths the MMU is built with.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-ported MMU.
// One transaction in flight; all outputs are registered.
//
// Handshake: a requester raises req with its address/count/data stable and
// holds it until its done pulse; the MMU sees a strobe held from grant until
// the matching ready pulse (or the timeout abort), then one idle cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [1:0]        f_cnt,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_cnt,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_cnt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rready,
  input  logic              mem_wready,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic            win;
  logic            win_we;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            f_wins;
  logic            ready_hit;

  assign dbg_state = state;

  // A waiting fetch only overtakes data once data has won STARVE_LIMIT times in a row.
  always_comb begin
    f_wins    = f_req && (!d_req || (starve_cnt == SW'(STARVE_LIMIT)));
    ready_hit = win_we ? mem_wready : mem_rready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      win         <= PORT_F;
      win_we      <= 1'b0;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      f_rdata     <= '0;
      f_done      <= 1'b0;
      d_rdata     <= '0;
      d_done      <= 1'b0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
      mem_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      if (!f_req) starve_cnt <= '0;

      case (state)
        ST_IDLE: begin
          if (f_req || d_req) begin
            tmo_cnt <= '0;
            state   <= ST_WAIT;
            if (f_wins) begin
              win         <= PORT_F;
              win_we      <= 1'b0;
              mem_address <= f_addr;
              mem_cnt     <= f_cnt;
              mem_wdata   <= '0;
              mem_read    <= 1'b1;
              starve_cnt  <= '0;
            end else begin
              win         <= PORT_D;
              win_we      <= d_we;
              mem_address <= d_addr;
              mem_cnt     <= d_cnt;
              mem_wdata   <= d_wdata;
              mem_read    <= !d_we;
              mem_write   <= d_we;
              if (f_req && (starve_cnt != SW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (ready_hit || (tmo_cnt == TW'(TIMEOUT - 1))) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= ST_RELEASE;
            if (win == PORT_F) f_done <= 1'b1;
            else               d_done <= 1'b1;
            if (!ready_hit) begin
              timeout_err <= 1'b1;
              if (win == PORT_F) f_rdata <= '0;
              else               d_rdata <= '0;
            end else if (!win_we) begin
              if (win == PORT_F) f_rdata <= mem_rdata;
              else               d_rdata <= mem_rdata;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_RELEASE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
